uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the successor to the fixed 8N1 receiver and feeds the SoC UART peripheral's RX path. It adds configurable baud divisor, data width, parity mode and stop-bit count, plus an input synchroniser and false-start rejection. It reports parity, framing and overrun errors and hands off data through a valid/ready holding register.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per UART bit (100 MHz / 9600); must be >= 4
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  input  1  system clock; single clock domain
i_rst  input  1  synchronous, active-high reset
i_rx_data  input  1  asynchronous serial line; idles high
i_ready  input  1  consumer accepts o_data when o_valid && i_ready
o_valid  output  1  holding register holds an unread frame
o_data  output  DATA_BITS  received data
o_parity_err  output  1  parity mismatch for the frame in o_data (0 when PARITY = 0)
o_frame_err  output  1  a stop bit sampled low for the frame in o_data
o_overrun  output  1  one-cycle pulse: completed frame dropped because the holding register was full
o_busy  output  1  high in any state except IDLE

Behaviour:
- Reset: clock and reset are as already decided (one clock; reset is synchronous and active-high). On a cycle with i_rst high, every output goes to 0, the state goes to IDLE, all counters clear and both synchroniser flops go to 1. Reset mid-frame abandons the frame and produces no output.
- Synchroniser: two flops; rx_s is the second flop.
- HALF = CLKS_PER_BIT/2 (integer). cnt is ceil(log2(CLKS_PER_BIT)) wide. NB = DATA_BITS + (PARITY != 0) + STOP_BITS.
- IDLE: when rx_s == 0, go to START with cnt = 0.
- START: cnt increments each cycle. At the edge where cnt == HALF-1, sample rx_s:
  - 0: go to DATA with cnt = 0 and bit index = 0.
  - 1: glitch; return to IDLE. No output and no flags.
- DATA: at the edge where cnt == CLKS_PER_BIT-1, shift rx_s in LSB first and clear cnt. After DATA_BITS samples, go to PARITY if PARITY != 0, else to STOP.
- PARITY: sample at the same point as DATA.
  - perr = XOR(data, pbit) compared with the mode: odd mode requires the XOR to be 1; even mode requires it to be 0.
- STOP: sample each stop bit at cnt == CLKS_PER_BIT-1. Any low stop sample sets ferr.
- Final stop-sample edge (the delivery edge):
  - The frame is delivered on this same edge.
  - Next state is IDLE, or WAIT_HIGH if ferr.
  - WAIT_HIGH stays until rx_s == 1, then goes to IDLE. This prevents a break condition retriggering the receiver.
- Latency: let t0 be the first edge at which i_rx_data is sampled low. o_valid rises after edge t0 + 2 + HALF + NB*CLKS_PER_BIT.
  - 8N1 at the default divisor: 98954 cycles.
- Holding register, at the delivery edge:
  - If o_valid == 0, or (o_valid && i_ready): load o_data, o_parity_err and o_frame_err together and set o_valid = 1. Simultaneous consume and deliver leaves o_valid high with the new data and no overrun.
  - Else: drop the new frame, keep the old data and flags, and pulse o_overrun for one cycle.
- Without a delivery: o_valid && i_ready clears o_valid on the next edge. o_data and the error flags hold their values until the next load.
- Frames with errors are still delivered. The errors are only flagged.
- Back-to-back frames (a start bit immediately after the stop bit) are received with no lost frame.

Test Plan:
1. Bench CLKS_PER_BIT=16, 8N1, i_ready=1; send 0xA5 → o_valid asserts 2+8+9*16=154 cycles after t0; o_data=8'hA5; no error flags.
2. PARITY=2 (even); send 0x3C with parity bit 1 → o_data=8'h3C, o_parity_err=1. Resend with parity bit 0 → o_parity_err=0.
3. Send 0x81 with the stop bit low, then hold the line low for 5 bit times → o_frame_err=1; o_busy stays high (WAIT_HIGH) until the line returns high; no second frame is produced.
4. i_ready=0; send 0x11 then 0x22 back-to-back → o_data stays 8'h11 and o_overrun pulses one cycle at the second delivery edge. Then raise i_ready for one cycle → o_valid drops.
5. Pull the line low for 4 cycles only (< HALF+2) → no o_valid, and the state returns to IDLE. Assert i_rst mid-byte → all outputs 0; the next full frame, 0x5A, is received correctly.
6. Default parameters (CLKS_PER_BIT=10416), send 0x5A then 0x0F back-to-back → both received; first o_valid 98954 cycles after t0.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, false-start rejection,
// optional parity, 1-2 stop bits, valid/ready holding register with overrun.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_rx_data,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_M1   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      state        <= S_IDLE;
      cnt          <= '0;
      idx          <= '0;
      shreg        <= '0;
      perr         <= 1'b0;
      ferr         <= 1'b0;
      o_valid      <= 1'b0;
      o_data       <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      rx_meta   <= i_rx_data;
      rx_s      <= rx_meta;
      o_overrun <= 1'b0;
      // A consume on this edge may be overridden below by a same-edge delivery.
      if (o_valid && i_ready) o_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == HALF_M1) begin
            cnt   <= '0;
            idx   <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            state <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == LAST_DATA) begin
              idx   <= '0;
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt == BIT_M1) begin
            cnt   <= '0;
            perr  <= (PARITY == 1) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
            state <= S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (cnt == BIT_M1) begin
            cnt <= '0;
            if (idx == LAST_STOP) begin
              // Delivery edge: the last stop sample folds straight into the flag.
              if (!o_valid || i_ready) begin
                o_valid      <= 1'b1;
                o_data       <= shreg;
                o_parity_err <= perr;
                o_frame_err  <= ferr | ~rx_s;
              end else begin
                o_overrun <= 1'b1;
              end
              idx   <= '0;
              state <= (ferr | ~rx_s) ? S_WAIT_HIGH : S_IDLE;
            end else begin
              ferr <= ferr | ~rx_s;
              idx  <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four configurations, table vectors, directed corner
// sequences and random frames checked against a frame-level reference model.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] rx, rdy, v, pe, fe, ov, bz;
  logic [7:0] d0, d1, d3;
  logic [6:0] d2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: 8N1/16   1: 8E1/16   2: 7O2/16   3: 8N1/1001 (odd divisor)
  int cpb_of[4]   = '{16, 16, 16, 1001};
  int dbits_of[4] = '{8, 8, 7, 8};
  int pm_of[4]    = '{0, 2, 1, 0};
  int ns_of[4]    = '{1, 1, 2, 1};

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .i_rst(rst), .i_rx_data(rx[0]), .i_ready(rdy[0]), .o_valid(v[0]),
    .o_data(d0), .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_overrun(ov[0]), .o_busy(bz[0]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .i_rst(rst), .i_rx_data(rx[1]), .i_ready(rdy[1]), .o_valid(v[1]),
    .o_data(d1), .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_overrun(ov[1]), .o_busy(bz[1]));
  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .i_rst(rst), .i_rx_data(rx[2]), .i_ready(rdy[2]), .o_valid(v[2]),
    .o_data(d2), .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_overrun(ov[2]), .o_busy(bz[2]));
  uart_rx_param #(.CLKS_PER_BIT(1001), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u3 (
    .clk(clk), .i_rst(rst), .i_rx_data(rx[3]), .i_ready(rdy[3]), .o_valid(v[3]),
    .o_data(d3), .o_parity_err(pe[3]), .o_frame_err(fe[3]), .o_overrun(ov[3]), .o_busy(bz[3]));

  typedef struct {
    int         k;
    logic [8:0] d;
    logic       pe;
    logic       fe;
    int         cyc;
  } rec_t;

  typedef struct {
    int         k;
    logic [8:0] data;
    logic       pbit;
    logic [1:0] stoplow;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  rec_t ldq[$];
  rec_t ovq[$];
  rec_t exq[$];
  int   nchk = 0;
  int   nfail = 0;
  int   t0_last;

  function automatic logic [8:0] get_d(input int k);
    case (k)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      2:       return {2'b00, d2};
      default: return {1'b0, d3};
    endcase
  endfunction

  // A load is a cycle where o_valid is high and was either low or consumed before.
  logic [3:0] pv, prdy;
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      rec_t r;
      r.k = k; r.d = get_d(k); r.pe = pe[k]; r.fe = fe[k]; r.cyc = cyc;
      if (v[k] === 1'b1 && (pv[k] !== 1'b1 || prdy[k] === 1'b1)) ldq.push_back(r);
      if (ov[k] === 1'b1) ovq.push_back(r);
    end
    pv   = v;
    prdy = rdy;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_loads(input int want, input int budget);
    int w;
    w = 0;
    while (ldq.size() < want && w < budget) begin
      tick(1);
      w++;
    end
  endtask

  // Reference model: frame bits, parity verdict and latency from the frame rules.
  function automatic void mkbits(input int k, input logic [8:0] data, input logic pbit,
                                 input logic [1:0] stoplow, output logic [15:0] bits,
                                 output int n);
    bits = '1;
    n = 0;
    for (int i = 0; i < dbits_of[k]; i++) begin bits[n] = data[i]; n++; end
    if (pm_of[k] != 0) begin bits[n] = pbit; n++; end
    for (int i = 0; i < ns_of[k]; i++) begin bits[n] = ~stoplow[i]; n++; end
  endfunction

  function automatic logic exp_perr(input int k, input logic [8:0] data, input logic pbit);
    int ones;
    ones = int'(pbit);
    for (int i = 0; i < dbits_of[k]; i++) ones += int'(data[i]);
    if (pm_of[k] == 0) return 1'b0;
    if (pm_of[k] == 1) return (ones % 2) == 0;
    return (ones % 2) == 1;
  endfunction

  function automatic int exp_lat(input int k);
    return 2 + cpb_of[k] / 2 + (dbits_of[k] + (pm_of[k] != 0 ? 1 : 0) + ns_of[k]) * cpb_of[k];
  endfunction

  // Called at posedge+1; the start bit is first sampled on the next edge.
  task automatic send_frame(input int k, input logic [15:0] bits, input int n);
    t0_last = cyc + 1;
    for (int i = -1; i < n; i++) begin
      rx[k] = (i < 0) ? 1'b0 : bits[i];
      tick(cpb_of[k]);
    end
  endtask

  task automatic send_byte(input int k, input logic [8:0] data);
    logic [15:0] b;
    int          n;
    mkbits(k, data, 1'b0, 2'b00, b, n);
    send_frame(k, b, n);
  endtask

  vec_t tbl[9];

  initial begin
    logic [15:0] bits;
    int          n, t0a, t0b, lows;

    tbl[0] = '{0, 9'h0A5, 1'b0, 2'b00, 9'h0A5, 1'b0, 1'b0};
    tbl[1] = '{1, 9'h03C, 1'b1, 2'b00, 9'h03C, 1'b1, 1'b0};
    tbl[2] = '{1, 9'h03C, 1'b0, 2'b00, 9'h03C, 1'b0, 1'b0};
    tbl[3] = '{1, 9'h007, 1'b1, 2'b00, 9'h007, 1'b0, 1'b0};
    tbl[4] = '{2, 9'h055, 1'b1, 2'b00, 9'h055, 1'b0, 1'b0};
    tbl[5] = '{2, 9'h07F, 1'b1, 2'b00, 9'h07F, 1'b1, 1'b0};
    tbl[6] = '{2, 9'h000, 1'b1, 2'b10, 9'h000, 1'b0, 1'b1};
    tbl[7] = '{2, 9'h02A, 1'b0, 2'b01, 9'h02A, 1'b0, 1'b1};
    tbl[8] = '{0, 9'h0FF, 1'b0, 2'b01, 9'h0FF, 1'b0, 1'b1};

    rst = 1'b1; rx = '1; rdy = '1;
    tick(3);
    rst = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("reset_outputs_%0d", k), {v[k], pe[k], fe[k], ov[k], bz[k], get_d(k)}, 32'd0);
    tick(4);

    for (int i = 0; i < 9; i++) begin
      int k;
      k = tbl[i].k;
      ldq.delete();
      mkbits(k, tbl[i].data, tbl[i].pbit, tbl[i].stoplow, bits, n);
      send_frame(k, bits, n);
      rx[k] = 1'b1;
      wait_loads(1, 40);
      chk($sformatf("tbl%0d_loads", i), ldq.size(), 1);
      if (ldq.size() > 0) begin
        chk($sformatf("tbl%0d_data", i), ldq[0].d, tbl[i].exp_d);
        chk($sformatf("tbl%0d_perr", i), ldq[0].pe, tbl[i].exp_pe);
        chk($sformatf("tbl%0d_ferr", i), ldq[0].fe, tbl[i].exp_fe);
        chk($sformatf("tbl%0d_latency", i), ldq[0].cyc - t0_last, exp_lat(k));
      end
      tick(8);
    end

    for (int s = 0; s < 2; s++) begin
      int k;
      k = (s == 0) ? 0 : 2;
      ldq.delete(); ovq.delete(); exq.delete();
      for (int f = 0; f < 24; f++) begin
        rec_t       e;
        logic [8:0] dat;
        logic       pb;
        logic [1:0] sl;
        int         gap;
        dat = 9'($urandom) & 9'((1 << dbits_of[k]) - 1);
        pb  = 1'($urandom);
        sl  = 2'b00;
        if ($urandom_range(0, 4) == 0) sl = (ns_of[k] == 2) ? 2'($urandom_range(1, 3)) : 2'b01;
        mkbits(k, dat, pb, sl, bits, n);
        send_frame(k, bits, n);
        e.k = k; e.d = dat; e.pe = exp_perr(k, dat, pb); e.fe = (sl != 2'b00);
        e.cyc = t0_last + exp_lat(k);
        exq.push_back(e);
        gap = (sl != 2'b00) ? $urandom_range(2, 5) : $urandom_range(0, 3);
        if (gap > 0) begin rx[k] = 1'b1; tick(gap); end
      end
      rx[k] = 1'b1;
      wait_loads(exq.size(), 60);
      chk($sformatf("rnd%0d_loads", k), ldq.size(), exq.size());
      for (int f = 0; f < exq.size() && f < ldq.size(); f++) begin
        chk($sformatf("rnd%0d_f%0d_data", k, f), ldq[f].d, exq[f].d);
        chk($sformatf("rnd%0d_f%0d_perr", k, f), ldq[f].pe, exq[f].pe);
        chk($sformatf("rnd%0d_f%0d_ferr", k, f), ldq[f].fe, exq[f].fe);
        chk($sformatf("rnd%0d_f%0d_cycle", k, f), ldq[f].cyc, exq[f].cyc);
      end
      chk($sformatf("rnd%0d_overruns", k), ovq.size(), 0);
      tick(8);
    end

    // Stop bit low followed by a long break: one frame, busy throughout.
    ldq.delete();
    mkbits(0, 9'h081, 1'b0, 2'b01, bits, n);
    send_frame(0, bits, n);
    lows = 0;
    for (int i = 0; i < 5 * 16; i++) begin
      tick(1);
      if (bz[0] !== 1'b1) lows++;
    end
    chk("break_busy_low_cycles", lows, 0);
    rx[0] = 1'b1;
    tick(4);
    chk("break_busy_after_release", bz[0], 1'b0);
    tick(30);
    chk("break_loads", ldq.size(), 1);
    if (ldq.size() > 0) begin
      chk("break_data", ldq[0].d, 9'h081);
      chk("break_ferr", ldq[0].fe, 1'b1);
      chk("break_perr", ldq[0].pe, 1'b0);
    end

    // Overrun: second back-to-back frame dropped while the first is unread.
    ldq.delete(); ovq.delete();
    rdy[0] = 1'b0;
    send_byte(0, 9'h011); t0a = t0_last;
    send_byte(0, 9'h022); t0b = t0_last;
    rx[0] = 1'b1;
    tick(20);
    chk("ovr_loads", ldq.size(), 1);
    if (ldq.size() > 0) chk("ovr_first_latency", ldq[0].cyc - t0a, 154);
    chk("ovr_pulse_cycles", ovq.size(), 1);
    if (ovq.size() > 0) chk("ovr_pulse_edge", ovq[0].cyc - t0b, 154);
    chk("ovr_data_held", d0, 8'h11);
    chk("ovr_valid_held", v[0], 1'b1);
    rdy[0] = 1'b1;
    tick(1);
    rdy[0] = 1'b0;
    chk("ovr_valid_consumed", v[0], 1'b0);
    chk("ovr_data_after_consume", d0, 8'h11);
    rdy[0] = 1'b1;
    tick(8);

    // Short glitch is rejected as a false start.
    ldq.delete();
    rx[0] = 1'b0;
    tick(4);
    chk("glitch_busy_in_start", bz[0], 1'b1);
    rx[0] = 1'b1;
    tick(30);
    chk("glitch_busy_idle", bz[0], 1'b0);
    chk("glitch_loads", ldq.size(), 0);

    // Reset mid-byte, then a clean frame.
    rx[0] = 1'b0; tick(16);
    rx[0] = 1'b1; tick(48);
    rx[0] = 1'b0; tick(16);
    rx[0] = 1'b1;
    chk("midrst_busy_before", bz[0], 1'b1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midrst_outputs", {v[0], pe[0], fe[0], ov[0], bz[0], d0}, 13'd0);
    tick(20);
    ldq.delete();
    send_byte(0, 9'h05A);
    wait_loads(1, 40);
    chk("post_rst_loads", ldq.size(), 1);
    if (ldq.size() > 0) begin
      chk("post_rst_data", ldq[0].d, 9'h05A);
      chk("post_rst_flags", {ldq[0].pe, ldq[0].fe}, 2'b00);
      chk("post_rst_latency", ldq[0].cyc - t0_last, 154);
    end
    tick(8);

    // Large odd divisor, back-to-back frames.
    ldq.delete(); ovq.delete();
    send_byte(3, 9'h05A); t0a = t0_last;
    send_byte(3, 9'h00F); t0b = t0_last;
    rx[3] = 1'b1;
    wait_loads(2, 100);
    chk("big_loads", ldq.size(), 2);
    if (ldq.size() > 1) begin
      chk("big_data0", ldq[0].d, 9'h05A);
      chk("big_latency0", ldq[0].cyc - t0a, 9511);
      chk("big_data1", ldq[1].d, 9'h00F);
      chk("big_latency1", ldq[1].cyc - t0b, 9511);
    end
    chk("big_overruns", ovq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

endmodule
